pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch front end of the pipeline. Holds the program counter, selects the next PC from the sequential (PC+4), branch-redirect and jump-redirect sources, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register with a valid bit. Hazard-unit stalls and control-transfer flushes are applied here, so downstream stages see only a clean, bubble-tagged instruction stream.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on reset or flush
- clk  input  1  rising-edge clock, the single clock of the block
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk
- stall  input  1  hazard unit: hold PC and IF/ID contents
- branch_taken  input  1  branch resolved taken in ID
- branch_target  input  32  branch destination byte address
- jump  input  1  unconditional jump decoded in ID
- jump_target  input  32  jump destination byte address
- imem_data  input  32  instruction word at imem_addr (combinational read, same cycle)
- imem_addr  output  32  current PC, to instruction memory
- pc  output  32  current PC (same value as imem_addr)
- if_id_instr  output  32  registered instruction word
- if_id_pc_plus4  output  32  registered PC+4 of that instruction
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- redirect_count  output  16  number of accepted redirects since reset, saturating

## Operation
- Internal registers: pc_q (32), IF/ID {instr, pc_plus4, valid}, redirect_count.
- pc_plus4 = pc_q + 32'd4, 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no flag.
- Targets: bits [1:0] of branch_target / jump_target are forced to 2'b00 before loading.
- Next-state priority per edge (highest first):
  - reset: pc_q <= RESET_PC; instr <= NOP_WORD; pc_plus4 <= 0; valid <= 0; redirect_count <= 0.
  - branch_taken: pc_q <= branch_target; IF/ID <= {NOP_WORD, 0, valid 0} (flush); count++.
  - jump (branch_taken = 0): pc_q <= jump_target; flush as above; count++.
  - stall: pc_q, IF/ID unchanged.
  - otherwise: pc_q <= pc_plus4; instr <= imem_data; if_id_pc_plus4 <= pc_plus4; valid <= 1.
- Redirect overrides stall: a redirect asserted in a stall cycle is taken, the flush replaces the stalled IF/ID contents.
- branch_taken and jump together: branch wins, one redirect counted.
- redirect_count saturates at 16'hFFFF; no wrap.
- Operating modes (implicit FSM via valid): BOOT (post-reset, valid=0) -> RUN on first non-stall, non-redirect edge; RUN -> BUBBLE on redirect; BUBBLE -> RUN on next non-stall edge; any -> BOOT on reset.

## Timing
- Reset values: pc = imem_addr = RESET_PC, if_id_instr = NOP_WORD, if_id_pc_plus4 = 0, if_id_valid = 0, redirect_count = 0.
- imem_addr = pc_q combinationally; imem_data must be valid before the next rising edge.
- Fetch latency: word at address A appears on if_id_instr exactly 1 cycle after pc = A (no stall).
- Redirect penalty: redirect asserted in cycle n -> pc = target in n+1, bubble in IF/ID in n+1, target's instruction in IF/ID in n+2.
- Stall for k cycles: pc and IF/ID frozen for k cycles, sequence resumes with no lost or duplicated instruction.
- Reset mid-operation: takes effect on the edge it is sampled, overriding stall and redirects; no partial updates.
- All outputs are register outputs or direct copies of pc_q; no combinational input-to-output path except none (imem_addr depends only on pc_q).

## Test plan
- Reset then 4 free-running cycles, imem returns addr|32'hA000_0000 -> pc 0,4,8,C,10; if_id_instr A0000000, A0000004, A0000008, A000000C; valid 0 then 1.
- Stall 3 cycles at pc=8 -> pc stays 8, if_id_instr stays A0000004 for 3 cycles, then A0000008 with pc=C; no gaps.
- branch_taken with target 32'h0000_0103 at pc=10 -> next pc 32'h100, valid 0 one cycle, then if_id_instr A0000100, if_id_pc_plus4 104, redirect_count 1.
- branch_taken and jump together (targets 200, 300) while stall=1 -> pc 200, bubble, count increments by exactly 1.
- RESET_PC=32'hFFFF_FFFC, run 2 cycles -> pc FFFFFFFC then 0; if_id_pc_plus4 = 0 for first instruction.
- Reset asserted during a jump cycle -> pc = RESET_PC, valid 0, redirect_count 0; 70000 forced redirects -> count holds FFFF.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC select,
// IF/ID capture with stall, flush and saturating redirect count.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [15:0] redirect_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  if_id_t      if_id_q;
  logic [15:0] cnt_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = branch_taken | jump;

  // branch has priority when both redirects arrive together
  always_comb begin
    target = jump_target & 32'hFFFF_FFFC;
    if (branch_taken)
      target = branch_target & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= '{instr: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0};
      cnt_q   <= 16'd0;
    end else if (redirect) begin
      pc_q    <= target;
      if_id_q <= '{instr: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0};
      if (cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end else if (!stall) begin
      pc_q    <= pc_plus4;
      if_id_q <= '{instr: imem_data, pc_plus4: pc_plus4, valid: 1'b1};
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: model pushes expected state
// per edge, each scenario task pops and compares after the edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] imem_data, imem_addr, pc;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;
  logic [15:0] redirect_count;

  logic [31:0] imem_data1, imem_addr1, pc1;
  logic [31:0] instr1, pp41;
  logic        valid1;
  logic [15:0] cnt1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t got;

  logic [31:0] mpc, minstr, mpp4;
  logic        mvalid;
  logic [15:0] mcnt;

  always #5 clk = ~clk;

  assign imem_data  = imem_addr | 32'hA000_0000;
  assign imem_data1 = imem_addr1 | 32'hA000_0000;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_data(imem_data), .imem_addr(imem_addr), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .redirect_count(redirect_count)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_data(imem_data1), .imem_addr(imem_addr1), .pc(pc1),
    .if_id_instr(instr1), .if_id_pc_plus4(pp41),
    .if_id_valid(valid1), .redirect_count(cnt1)
  );

  assign got = '{pc: pc, instr: if_id_instr, pp4: if_id_pc_plus4,
                 valid: if_id_valid, cnt: redirect_count};

  task automatic cycle(input logic r, input logic s,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    @(negedge clk);
    reset = r; stall = s;
    branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    if (r) begin
      mpc = 32'd0; minstr = 32'd0; mpp4 = 32'd0;
      mvalid = 1'b0; mcnt = 16'd0;
    end else if (b || j) begin
      mpc = b ? {bt[31:2], 2'b00} : {jt[31:2], 2'b00};
      minstr = 32'd0; mpp4 = 32'd0; mvalid = 1'b0;
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    end else if (!s) begin
      minstr = mpc | 32'hA000_0000;
      mpp4 = mpc + 32'd4;
      mvalid = 1'b1;
      mpc = mpc + 32'd4;
    end
    sb.push_back('{pc: mpc, instr: minstr, pp4: mpp4,
                   valid: mvalid, cnt: mcnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", got, e);
    end
    checks++;
    if ({pc, if_id_valid, redirect_count} !== 49'd0) begin
      failures++;
      $display("FAIL reset_const pc=%h v=%b c=%h", pc, if_id_valid,
               redirect_count);
    end
  endtask

  task automatic test_run_stall;
    for (int i = 0; i < 7; i++) begin
      cycle(0, (i >= 2 && i < 5), 0, 0, 0, 0);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL run_stall[%0d] got=%h exp=%h", i, got, e);
      end
    end
    checks++;
    if (pc !== 32'h10 || if_id_instr !== 32'hA000_000C) begin
      failures++;
      $display("FAIL run_stall_end pc=%h instr=%h exp 10/A000000C",
               pc, if_id_instr);
    end
  endtask

  task automatic test_branch;
    cycle(0, 0, 1, 32'h0000_0103, 0, 0);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL branch got=%h exp=%h", got, e);
    end
    cycle(0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL branch_fetch got=%h exp=%h", got, e);
    end
    checks++;
    if (if_id_instr !== 32'hA000_0100 || if_id_pc_plus4 !== 32'h104
        || redirect_count !== 16'd1) begin
      failures++;
      $display("FAIL branch_const instr=%h pp4=%h cnt=%h",
               if_id_instr, if_id_pc_plus4, redirect_count);
    end
  endtask

  task automatic test_both_stalled;
    cycle(0, 1, 1, 32'h200, 1, 32'h300);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL both got=%h exp=%h", got, e);
    end
    checks++;
    if (pc !== 32'h200 || if_id_valid !== 1'b0
        || redirect_count !== 16'd2) begin
      failures++;
      $display("FAIL both_const pc=%h v=%b cnt=%h exp 200/0/2",
               pc, if_id_valid, redirect_count);
    end
  endtask

  task automatic test_reset_in_jump;
    cycle(0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    cycle(1, 1, 0, 0, 1, 32'h400);
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset_jump got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_saturate;
    int bad;
    bad = 0;
    for (int i = 0; i < 70000; i++) begin
      cycle(0, 0, 0, 0, 1, 32'h40 + 32'(i[3:0]) * 4);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        if (bad < 5)
          $display("FAIL saturate[%0d] got=%h exp=%h", i, got, e);
        bad++;
      end
    end
    checks++;
    if (redirect_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL saturate_hold cnt=%h exp=ffff", redirect_count);
    end
  endtask

  task automatic test_wrap;
    cycle(1, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    checks++;
    if (pc1 !== 32'hFFFF_FFFC || valid1 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_reset pc=%h v=%b exp fffffffc/0", pc1, valid1);
    end
    cycle(0, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    checks++;
    if (pc1 !== 32'h0 || pp41 !== 32'h0 || instr1 !== 32'hFFFF_FFFC
        || valid1 !== 1'b1) begin
      failures++;
      $display("FAIL wrap pc=%h pp4=%h instr=%h v=%b", pc1, pp41,
               instr1, valid1);
    end
  endtask

  initial begin
    test_reset;
    test_run_stall;
    test_branch;
    test_both_stalled;
    test_reset_in_jump;
    test_saturate;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
